// File: rtl/arbitro_paralelo_serial.sv
// -----------------------------------------------------------------------------
// arbitro_paralelo_serial
//
// Round-robin scheduler that shares one parallel-to-serial converter among
// N_REQ byte sources (lane FIFOs) in the transmit path. After reset it sends
// INIT_COMMAS idle commas. It then grants the converter to one source at a
// time, for bursts of up to MAX_BURST bytes.
//
// Ports
//   clk4_f     in   byte-rate clock, all logic on its rising edge
//   reset      in   asynchronous, active-high reset
//   valid_in   in   [N_REQ]     per-source "byte available"
//   data_in    in   [N_REQ*BW]  source i occupies bits [i*BW +: BW]
//   pop        out  [N_REQ]     combinational, one-hot or zero; the source
//                               consumes its byte on the edge where it is set
//   data_out   out  [BW]        registered byte to the serializer
//   valid_out  out              registered, 1 = data_out is payload
//   grant      out  [N_REQ]     registered one-hot owner of data_out, 0 idle
//   active     out              registered, 1 once initialisation is complete
// -----------------------------------------------------------------------------
module arbitro_paralelo_serial #(
  parameter int            N_REQ       = 4,
  parameter int            BW          = 8,
  parameter int            MAX_BURST   = 4,
  parameter int            INIT_COMMAS = 4,
  parameter logic [BW-1:0] IDLE_SYM    = BW'(8'hBC)
) (
  input  logic                clk4_f,
  input  logic                reset,
  input  logic [N_REQ-1:0]    valid_in,
  input  logic [N_REQ*BW-1:0] data_in,
  output logic [N_REQ-1:0]    pop,
  output logic [BW-1:0]       data_out,
  output logic                valid_out,
  output logic [N_REQ-1:0]    grant,
  output logic                active
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int BC_W  = $clog2(MAX_BURST + 1);
  localparam int IC_W  = $clog2(INIT_COMMAS + 1);

  localparam logic [PTR_W:0]     N_REQ_W    = (PTR_W + 1)'(N_REQ);
  localparam logic [PTR_W-1:0]   LAST_IDX   = PTR_W'(N_REQ - 1);
  localparam logic [BC_W-1:0]    BURST_LAST = BC_W'(MAX_BURST - 1);
  localparam logic [IC_W-1:0]    INIT_LAST  = IC_W'(INIT_COMMAS - 1);
  localparam logic [N_REQ-1:0]   ONE_HOT0   = N_REQ'(1);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_SELECT = 2'd1,
    ST_BURST  = 2'd2
  } state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_owner;
  logic [BC_W-1:0]    r_burst_cnt;
  logic [IC_W-1:0]    r_init_cnt;
  logic [BW-1:0]      r_data;
  logic               r_valid;
  logic [N_REQ-1:0]   r_grant;
  logic               r_active;

  state_t             w_state_nxt;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic [PTR_W-1:0]   w_owner_nxt;
  logic [BC_W-1:0]    w_burst_nxt;
  logic [IC_W-1:0]    w_init_nxt;
  logic [BW-1:0]      w_data_nxt;
  logic               w_valid_nxt;
  logic [N_REQ-1:0]   w_grant_nxt;
  logic               w_active_nxt;
  logic [N_REQ-1:0]   w_pop;

  // Per-source byte view of the flat input bus.
  logic [BW-1:0] w_bytes [N_REQ];
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bytes
    assign w_bytes[gi] = data_in[gi*BW +: BW];
  end

  // Round-robin search: rotate valid_in so that bit 0 is the source at ptr,
  // take the lowest set bit, then map the offset back to a source index.
  logic [2*N_REQ-1:0] w_valid2;
  logic [N_REQ-1:0]   w_rot;
  logic               w_found;
  logic [PTR_W-1:0]   w_off;
  logic [PTR_W:0]     w_sum;
  logic [PTR_W-1:0]   w_sel;
  logic [PTR_W-1:0]   w_sel_inc;

  assign w_valid2 = {valid_in, valid_in};
  assign w_rot    = w_valid2[r_ptr +: N_REQ];

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    // Scanning downwards lets the lowest offset win the last assignment.
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_found = 1'b1;
        w_off   = PTR_W'(j);
      end
    end
  end

  assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_sel     = (w_sum >= N_REQ_W) ? PTR_W'(w_sum - N_REQ_W) : w_sum[PTR_W-1:0];
  assign w_sel_inc = (w_sel == LAST_IDX) ? '0 : w_sel + 1'b1;

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves it unassigned, which would otherwise infer a latch.
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_owner_nxt  = r_owner;
    w_burst_nxt  = r_burst_cnt;
    w_init_nxt   = r_init_cnt;
    w_data_nxt   = IDLE_SYM;
    w_valid_nxt  = 1'b0;
    w_grant_nxt  = r_grant;
    w_active_nxt = r_active;
    w_pop        = '0;

    case (r_state)
      ST_INIT: begin
        w_grant_nxt = '0;
        w_init_nxt  = r_init_cnt + 1'b1;
        if (r_init_cnt == INIT_LAST) begin
          w_active_nxt = 1'b1;
          w_state_nxt  = ST_SELECT;
        end
      end

      ST_SELECT: begin
        if (w_found) begin
          w_pop       = ONE_HOT0 << w_sel;
          w_data_nxt  = w_bytes[w_sel];
          w_valid_nxt = 1'b1;
          w_grant_nxt = ONE_HOT0 << w_sel;
          w_owner_nxt = w_sel;
          w_burst_nxt = BC_W'(1);
          w_ptr_nxt   = w_sel_inc;
          w_state_nxt = (MAX_BURST > 1) ? ST_BURST : ST_SELECT;
        end else begin
          w_grant_nxt = '0;
        end
      end

      ST_BURST: begin
        if (valid_in[r_owner]) begin
          w_pop       = ONE_HOT0 << r_owner;
          w_data_nxt  = w_bytes[r_owner];
          w_valid_nxt = 1'b1;
          w_burst_nxt = r_burst_cnt + 1'b1;
          if (r_burst_cnt == BURST_LAST) begin
            w_state_nxt = ST_SELECT;
          end
        end else begin
          // Owner ran dry: one bubble, then arbitration resumes at owner+1
          // because ptr already moved past it when the burst was granted.
          w_grant_nxt = '0;
          w_state_nxt = ST_SELECT;
        end
      end

      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk4_f or posedge reset) begin
    if (reset) begin
      r_state     <= ST_INIT;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_burst_cnt <= '0;
      r_init_cnt  <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_grant     <= '0;
      r_active    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed from pre-edge state, independent of statement order.
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_owner     <= w_owner_nxt;
      r_burst_cnt <= w_burst_nxt;
      r_init_cnt  <= w_init_nxt;
      r_data      <= w_data_nxt;
      r_valid     <= w_valid_nxt;
      r_grant     <= w_grant_nxt;
      r_active    <= w_active_nxt;
    end
  end

  // pop only ever fires in SELECT/BURST, and reset forces INIT, so it is
  // zero for as long as reset is held.
  assign pop       = w_pop;
  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign grant     = r_grant;
  assign active    = r_active;

endmodule
